// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: round-robin arbiter that shares the decoder_3to8 select path
// among 8 level-sensitive requesters. It drives the decoder address (gnt_idx) and
// enable (gnt_valid), holds each grant while its request stays high, and always
// leaves one idle cycle between grants.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after MAX_HOLD grant cycles).

// Per-requester slice. It flags requests at or above the priority pointer and
// decodes this lane's one-hot grant bit.
module rr_arb_lane #(
  parameter int LANE = 0
) (
  input  logic       req_i,
  input  logic [2:0] ptr_i,
  input  logic       gnt_valid_i,
  input  logic [2:0] gnt_idx_i,
  output logic       hi_o,
  output logic       gnt_o
);
  localparam logic [2:0] LaneIdx = 3'(LANE);

  // Requests at or above ptr outrank the wrapped-around ones.
  assign hi_o  = req_i && (LaneIdx >= ptr_i);
  // Grant bit decoded purely from registered state, so it cannot glitch on req.
  assign gnt_o = gnt_valid_i && (gnt_idx_i == LaneIdx);
endmodule

module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic [7:0] gnt,
  output logic       timeout_pulse
);
  localparam int NUM_REQ = 8;
  localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;

  logic [NUM_REQ-1:0] hi;
  logic               win_found;
  logic [2:0]         win_idx;
  logic               req_held;
  logic               to_hit;

  // One lane per requester: priority masking and grant decode.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    rr_arb_lane #(.LANE(i)) u_lane (
      .req_i       (req[i]),
      .ptr_i       (ptr_q),
      .gnt_valid_i (gnt_valid_q),
      .gnt_idx_i   (gnt_idx_q),
      .hi_o        (hi[i]),
      .gnt_o       (gnt[i])
    );
  end

  // Rotating priority pick: lowest request at/above ptr, else lowest overall (wrap).
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hi[i]) win_idx = 3'(i);
    end
  end

  assign req_held = req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  logic timeout_q, timeout_d;

  assign to_hit = (hold_q == HoldMax);

  // Pulse only for a genuine forced release; a request dropping on the same
  // edge counts as a normal release.
  always_comb begin
    timeout_d = 1'b0;
    if (state_q == GRANT && to_hit && req_held) timeout_d = 1'b1;
  end

  // Timeout pulse register, high for the first GAP cycle after a forced release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_d;
  end

  assign timeout_pulse = timeout_q;
`else
  assign to_hit        = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  // Next-state and grant register updates for IDLE/GRANT/GAP.
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d     = GRANT;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_d      = 8'd0;
        end else begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!req_held || to_hit) begin
          // Released requester drops to lowest priority; idx wraps 7 -> 0.
          state_d     = GAP;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and grant registers; reset clears the enable asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= 3'd0;
      hold_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter. Built with ARB_TIMEOUT_EN it runs the
// forced-release sequence with MAX_HOLD=4; otherwise it checks a long hold.
module tb_rr_decoder_arbiter;
`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
  localparam int SINGLE_N = 3;
`else
  localparam int MH = 16;
  localparam int SINGLE_N = 5;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [7:0] gnt;
  logic       timeout_pulse;

  int checks = 0;
  int failures = 0;

  rr_decoder_arbiter #(.MAX_HOLD(MH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .gnt_idx       (gnt_idx),
    .gnt_valid     (gnt_valid),
    .gnt           (gnt),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks every output against an expected (valid, idx, timeout) triple.
  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                         input logic to);
    logic [7:0] eg;
    eg = v ? (8'h01 << idx) : 8'h00;
    chk({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, v});
    chk({tag, ".idx"}, {5'd0, gnt_idx}, {5'd0, idx});
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".to"}, {7'd0, timeout_pulse}, {7'd0, to});
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    // Reset with all requests high.
    req = 8'hFF;
    rst = 1'b1;
    #12;
    chk_out("reset", 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick(); chk_out("post_reset_grant", 1'b1, 3'd0, 1'b0);
    req = 8'h00;
    tick(); chk_out("post_reset_rel", 1'b0, 3'd0, 1'b0);
    tick(); chk_out("idle", 1'b0, 3'd0, 1'b0);

    // Single requester 5.
    req = 8'h20;
    for (int c = 0; c < SINGLE_N; c++) begin
      tick(); chk_out("single_hold", 1'b1, 3'd5, 1'b0);
    end
    req = 8'h00;
    tick(); chk_out("single_rel", 1'b0, 3'd5, 1'b0);
    tick();

    // Round robin over all 8 requesters from a fresh pointer.
    pulse_reset();
    chk_out("rr_reset", 1'b0, 3'd0, 1'b0);
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick(); chk_out("rr_grant", 1'b1, 3'(g % 8), 1'b0);
      if (g == 8) break;
      tick(); chk_out("rr_hold1", 1'b1, 3'(g % 8), 1'b0);
      tick(); chk_out("rr_hold2", 1'b1, 3'(g % 8), 1'b0);
      req[g % 8] = 1'b0;
      tick(); chk_out("rr_gap", 1'b0, 3'(g % 8), 1'b0);
      req[g % 8] = 1'b1;
    end

    // Wrap: pointer lands on 7 after releasing 6.
    req = 8'h00;
    tick(); chk_out("wrap_gap0", 1'b0, 3'd0, 1'b0);
    req = 8'h40;
    tick(); chk_out("wrap_g6", 1'b1, 3'd6, 1'b0);
    req = 8'h81;
    tick(); chk_out("wrap_gap6", 1'b0, 3'd6, 1'b0);
    tick(); chk_out("wrap_g7", 1'b1, 3'd7, 1'b0);
    req = 8'h01;
    tick(); chk_out("wrap_gap7", 1'b0, 3'd7, 1'b0);
    tick(); chk_out("wrap_g0", 1'b1, 3'd0, 1'b0);
    req = 8'h00;
    tick(); chk_out("wrap_rel0", 1'b0, 3'd0, 1'b0);
    tick();

    // Reset asserted during the second GRANT cycle; ptr was 1 beforehand.
    req = 8'h08;
    tick(); chk_out("mid_g3", 1'b1, 3'd3, 1'b0);
    tick(); chk_out("mid_g3b", 1'b1, 3'd3, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("mid_async", 1'b0, 3'd0, 1'b0);
    req = 8'h09;
    #2 rst = 1'b0;
    tick(); chk_out("mid_restart", 1'b1, 3'd0, 1'b0);
    req = 8'h00;
    tick(); chk_out("mid_rel", 1'b0, 3'd0, 1'b0);
    tick();

`ifdef ARB_TIMEOUT_EN
    // Forced release after 4 cycles, alternating between requesters 2 and 3.
    pulse_reset();
    req = 8'h0C;
    for (int c = 0; c < 4; c++) begin
      tick(); chk_out("to_g2", 1'b1, 3'd2, 1'b0);
    end
    tick(); chk_out("to_gap2", 1'b0, 3'd2, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick(); chk_out("to_g3", 1'b1, 3'd3, 1'b0);
    end
    tick(); chk_out("to_gap3", 1'b0, 3'd3, 1'b1);
    tick(); chk_out("to_g2_again", 1'b1, 3'd2, 1'b0);
    tick(); tick(); tick(); chk_out("to_g2_h3", 1'b1, 3'd2, 1'b0);
    // Request drops on the same edge the limit is reached: normal release.
    req = 8'h08;
    tick(); chk_out("to_simul", 1'b0, 3'd2, 1'b0);
    tick(); chk_out("to_after", 1'b1, 3'd3, 1'b0);
`else
    // No timeout: a grant well past MAX_HOLD cycles is kept.
    req = 8'h10;
    for (int c = 0; c < 20; c++) begin
      tick(); chk_out("long_hold", 1'b1, 3'd4, 1'b0);
    end
    req = 8'h00;
    tick(); chk_out("long_rel", 1'b0, 3'd4, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
